ex_stage_ctrl: RTL
==================

Name: ex_stage_ctrl

Overview:
Execute-stage controller for the 16-bit pipeline. It accepts decoded ops from ID over a valid/ready handshake and drives the existing ALU combinationally. It owns the condition-code register (CCR) and evaluates conditional branches. It holds each result in a one-entry output register until MEM accepts it, and supports flush plus interrupt save/restore of the CCR.

Parameters:
DATA_W, 16, operand/result width; must equal the ALU width, so only 16 is legal.
RA_W, 3, destination register address width (8 GPRs).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  ID presents an op
in_ready  out  1  controller can accept an op this cycle
in_op  in  3  ALU code: 000 NOP, 001 LDD, 010 STD, 011 ADD, 100 NOT, 111 LDM; others are treated as NOP
in_a  in  16  operand 1 (ALU in1)
in_b  in  16  operand 2 (ALU in2)
in_rd  in  3  destination register
in_br  in  2  branch type: 00 none, 01 JZ, 10 JN, 11 JC
in_setc  in  1  SETC: set C
in_clrc  in  1  CLRC: clear C
out_valid  out  1  output register holds a live op
out_ready  in  1  MEM accepts
out_result  out  16  registered ALU result
out_rd  out  3  registered destination
out_wb  out  1  write-back enable (ADD, NOT, LDD, LDM)
out_mem_wr  out  1  memory write (STD)
out_br_taken  out  1  branch condition met
flush  in  1  kill the incoming op and the output register
int_save  in  1  copy CCR to the shadow register
rti_restore  in  1  copy the shadow register to CCR
ccr  out  3  {N,C,Z} = ccr[2:0]

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid, out_result, out_rd, out_wb, out_mem_wr, out_br_taken = 0.
  - ccr = 000, shadow = 000.
  - Any held op is discarded; in_ready = 1 in the first cycle after reset.
- State machine over the output register:
  - States are EMPTY and FULL; in_ready = EMPTY | out_ready.
  - accept = in_valid & in_ready & !flush.
  - EMPTY->FULL on accept.
  - FULL->EMPTY on out_ready & !accept.
  - FULL->FULL on accept & out_ready (new op replaces old, zero bubbles).
  - Without out_ready, all out_* hold stable.
- Latency: one cycle from accept to out_valid; throughput is 1 op/cycle.
- Arithmetic:
  - ADD: result = in_a+in_b mod 2^16; carry = bit 16.
  - NOT: ~in_b.
  - LDD/LDM/STD: pass in_a.
  - NOP: result 0, out_wb = 0, out_mem_wr = 0.
- CCR commit happens on accept only, using the new result:
  - ADD: Z = (result==0), N = result[15], C = carry.
  - NOT: Z and N as for ADD; C unchanged.
  - Other ops: no arithmetic flag change.
  - in_setc/in_clrc are applied after arithmetic flags. in_setc wins if both are set.
- Branch:
  - out_br_taken = the tested flag (Z, N or C) as seen before this op's own flag update.
  - A taken branch clears the tested flag in the same commit.
  - in_br=00 gives taken=0.
- Flush:
  - Next cycle out_valid = 0.
  - The incoming op is dropped, no CCR change, and in_ready is unaffected.
  - Flush beats accept.
- Shadow register:
  - int_save captures the CCR value before any same-cycle commit.
  - rti_restore overrides any same-cycle commit; the CCR takes the shadow value.
  - int_save and rti_restore together: the CCR is restored from the old shadow, and the shadow is loaded with the old CCR.
- Reset mid-operation: rst_n beats flush, accept, save and restore.
- ccr output is the register value, not bypassed.

Decomposition:
- Shared package ex_pkg holds:
  - ALU op codes (OP_NOP, OP_LDD, OP_STD, OP_ADD, OP_NOT, OP_LDM).
  - Branch codes (BR_NONE, BR_JZ, BR_JN, BR_JC).
  - CCR bit indices Z_BIT=0, C_BIT=1, N_BIT=2.
- Sub-modules:
  - Instantiate the existing ALU for result and carry.
  - One natural sub-module, ccr_unit, holds the CCR, the shadow register and the commit/save/restore priority logic.

Test Plan:
- ADD 0xFFFF+0x0001 accepted -> next cycle out_result=0x0000, out_wb=1, ccr=3'b011 (N=0,C=1,Z=1).
- After that, NOT in_b=0x00FF -> out_result=0xFF00, ccr=3'b110 (N=1, C kept 1, Z=0).
- out_ready=0 for 3 cycles with the output register FULL:
  - in_ready=0 and out_* stay stable.
  - A second op is accepted the cycle out_ready=1, with no bubble.
- ccr Z=1, JZ op -> out_br_taken=1, Z cleared. JC with C=0 -> out_br_taken=0, ccr unchanged.
- int_save with ccr=3'b101, then ADD producing ccr=3'b000, then rti_restore -> ccr=3'b101. Restore in the same cycle as an ADD commit -> ccr=3'b101.
- flush asserted with in_valid=1 while FULL -> out_valid=0 next cycle and ccr unchanged. Also rst_n=0 mid-stall -> all outputs 0 and in_ready=1 next cycle.

Source files
------------

// File: rtl/ex_stage_ctrl_pkg.sv
// Shared definitions for the execute stage: ALU op codes, branch codes and CCR layout.
package ex_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDD = 3'b001;
    localparam logic [2:0] OP_STD = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_LDM = 3'b111;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_JZ   = 2'b01;
    localparam logic [1:0] BR_JN   = 2'b10;
    localparam logic [1:0] BR_JC   = 2'b11;

    localparam int Z_BIT = 0;
    localparam int C_BIT = 1;
    localparam int N_BIT = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic logic op_writes_back(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_NOT) || (op == OP_LDD) || (op == OP_LDM);
    endfunction

endpackage

// File: rtl/ex_stage_ctrl_alu.sv
// Combinational 16-bit ALU: ADD with carry-out, NOT of operand 2, pass-through of operand 1.
module ex_alu
    import ex_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] in1_i,
    input  logic [DATA_W-1:0] in2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, in1_i} + {1'b0, in2_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            OP_NOT:                 result_o = ~in2_i;
            OP_LDD, OP_LDM, OP_STD: result_o = in1_i;
            default:                result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage_ctrl_ccr_unit.sv
// Condition-code register with interrupt shadow copy; branch evaluation reads the pre-commit CCR.
module ccr_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic              carry_i,
    input  logic [1:0]        br_i,
    input  logic              setc_i,
    input  logic              clrc_i,
    input  logic              save_i,
    input  logic              restore_i,
    output logic [2:0]        ccr_o,
    output logic              br_taken_o
);

    logic [2:0] ccr_q, ccr_d;
    logic [2:0] shadow_q, shadow_d;
    logic [2:0] commit_val;

    always_comb begin
        br_taken_o = 1'b0;
        case (br_i)
            BR_JZ:   br_taken_o = ccr_q[Z_BIT];
            BR_JN:   br_taken_o = ccr_q[N_BIT];
            BR_JC:   br_taken_o = ccr_q[C_BIT];
            default: br_taken_o = 1'b0;
        endcase
    end

    // Order: arithmetic flags, then taken-branch clear, then explicit C set/clear.
    always_comb begin
        commit_val = ccr_q;
        if (op_i == OP_ADD || op_i == OP_NOT) begin
            commit_val[Z_BIT] = (result_i == '0);
            commit_val[N_BIT] = result_i[DATA_W-1];
        end
        if (op_i == OP_ADD) begin
            commit_val[C_BIT] = carry_i;
        end
        if (br_taken_o) begin
            case (br_i)
                BR_JZ:   commit_val[Z_BIT] = 1'b0;
                BR_JN:   commit_val[N_BIT] = 1'b0;
                BR_JC:   commit_val[C_BIT] = 1'b0;
                default: commit_val = commit_val;
            endcase
        end
        if (setc_i) begin
            commit_val[C_BIT] = 1'b1;
        end else if (clrc_i) begin
            commit_val[C_BIT] = 1'b0;
        end
    end

    always_comb begin
        ccr_d    = ccr_q;
        shadow_d = shadow_q;
        if (restore_i) begin
            ccr_d = shadow_q;
        end else if (commit_i) begin
            ccr_d = commit_val;
        end
        if (save_i) begin
            shadow_d = ccr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ccr_q    <= '0;
            shadow_q <= '0;
        end else begin
            ccr_q    <= ccr_d;
            shadow_q <= shadow_d;
        end
    end

    assign ccr_o = ccr_q;

endmodule

// File: rtl/ex_stage_ctrl.sv
// Execute-stage controller: valid/ready intake from ID, ALU drive, CCR ownership and a
// one-entry output register toward MEM with flush support.
module ex_stage_ctrl
    import ex_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [1:0]        in_br,
    input  logic              in_setc,
    input  logic              in_clrc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_wb,
    output logic              out_mem_wr,
    output logic              out_br_taken,
    input  logic              flush,
    input  logic              int_save,
    input  logic              rti_restore,
    output logic [2:0]        ccr
);

    out_state_e        state_q;
    logic [DATA_W-1:0] result_q;
    logic [RA_W-1:0]   rd_q;
    logic              wb_q;
    logic              mem_wr_q;
    logic              br_q;
    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              br_taken;

    assign in_ready = (state_q == ST_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    ex_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (in_op),
        .in1_i    (in_a),
        .in2_i    (in_b),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    ccr_unit #(
        .DATA_W (DATA_W)
    ) u_ccr (
        .clk        (clk),
        .rst_n      (rst_n),
        .commit_i   (accept),
        .op_i       (in_op),
        .result_i   (alu_result),
        .carry_i    (alu_carry),
        .br_i       (in_br),
        .setc_i     (in_setc),
        .clrc_i     (in_clrc),
        .save_i     (int_save),
        .restore_i  (rti_restore),
        .ccr_o      (ccr),
        .br_taken_o (br_taken)
    );

    // Flush only drops validity; payload registers keep their last value while EMPTY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            result_q <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            mem_wr_q <= 1'b0;
            br_q     <= 1'b0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else if (accept) begin
            state_q  <= ST_FULL;
            result_q <= alu_result;
            rd_q     <= in_rd;
            wb_q     <= op_writes_back(in_op);
            mem_wr_q <= (in_op == OP_STD);
            br_q     <= br_taken;
        end else if (out_ready) begin
            state_q <= ST_EMPTY;
        end
    end

    assign out_valid    = (state_q == ST_FULL);
    assign out_result   = result_q;
    assign out_rd       = rd_q;
    assign out_wb       = wb_q;
    assign out_mem_wr   = mem_wr_q;
    assign out_br_taken = br_q;

endmodule
